// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the 5-stage MIPS pipeline. It holds:
//     - the datapath width and the default reset PC and bubble word
//     - the J opcode
//     - the bit positions of the instruction fields
//     - the packed IF/ID payload type
//     - the jump-target helper
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int XLEN = 32;

  // Default PC loaded on reset.
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  // Bubble word: sll $0,$0,0.
  localparam logic [XLEN-1:0] NOP_WORD     = 32'h0000_0000;

  localparam logic [5:0] OP_J = 6'b000010;

  // Instruction field slices.
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int JIDX_MSB  = 25;
  localparam int JIDX_LSB  = 0;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // J-type target: upper nibble of PC+4, 26-bit index, word-aligned.
  function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0] pc_plus4,
                                                   input logic [XLEN-1:0] instr);
    return {pc_plus4[31:28], instr[JIDX_MSB:JIDX_LSB], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   Generic pipeline register with a synchronous clear and an enable.
//   - Clear has priority over enable.
//   - Clear and reset both load CLR_VAL.
//   It is written generically so the same block can serve as an ID/EX-style
//   register later.
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset (loads CLR_VAL)
//   clr_i  in   1      synchronous clear to CLR_VAL
//   en_i   in   1      load d_i when not clearing (0 = hold)
//   d_i    in   WIDTH  next contents
//   q_o    out  WIDTH  register contents
// -----------------------------------------------------------------------------
module if_id_reg #(
  parameter int               WIDTH   = 65,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i)     data_d = CLR_VAL;
    else if (en_i) data_d = d_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= CLR_VAL;
    else        data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   IF stage plus the IF/ID register of the 5-stage MIPS pipeline.
//   - Holds the PC and addresses a combinational-read instruction memory.
//   - Latches InstrD/PCPlus4D/ValidD for decode.
//   - Applies branch (PCSrcM) and jump redirects.
//   - Honours the stall and flush requests from the hazard unit.
// Ports
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   StallF      in   1   hold PC
//   StallD      in   1   hold IF/ID register
//   FlushD      in   1   bubble request for IF/ID
//   PCSrcM      in   1   taken branch resolved in M
//   PCBranchM   in   32  branch target
//   jump        in   1   J decoded in D
//   imem_addr   out  32  instruction memory address (= PCF)
//   imem_rdata  in   32  instruction at imem_addr, same cycle
//   PCF         out  32  current fetch PC
//   InstrD      out  32  instruction in decode
//   PCPlus4D    out  32  PC+4 of InstrD
//   ValidD      out  1   InstrD is a real instruction (0 = bubble)
//   op          out  6   InstrD[31:26]
//   funct       out  6   InstrD[5:0]
// -----------------------------------------------------------------------------
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcM,
  input  logic [31:0] PCBranchM,
  input  logic        jump,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [5:0]  op,
  output logic [5:0]  funct
);

  localparam if_id_t IF_ID_CLR = '{instr: NOP_INSTR, pc_plus4: 32'd0, valid: 1'b0};

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_f;
  logic [31:0] jta;
  logic        jump_taken;
  logic        if_id_clr;
  if_id_t      if_id_d;
  if_id_t      if_id_q;

  // Wraps naturally modulo 2^32.
  assign pc_plus4_f = pc_q + 32'd4;
  assign jta        = jump_target(if_id_q.pc_plus4, if_id_q.instr);
  // A J that was flushed (ValidD=0) must never redirect.
  assign jump_taken = jump & if_id_q.valid;

  // A resolved branch wins even over a fetch stall: the stalled instruction
  // is on the wrong path anyway.
  always_comb begin
    pc_d = pc_plus4_f;
    if (PCSrcM)          pc_d = PCBranchM;
    else if (StallF)     pc_d = pc_q;
    else if (jump_taken) pc_d = jta;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // The instruction fetched behind a taken jump is dropped. This only happens
  // when decode is actually advancing, otherwise the J itself would be lost.
  assign if_id_clr = PCSrcM | FlushD | (jump_taken & ~StallD);

  assign if_id_d = '{instr: imem_rdata, pc_plus4: pc_plus4_f, valid: 1'b1};

  if_id_reg #(
    .WIDTH  ($bits(if_id_t)),
    .CLR_VAL(IF_ID_CLR)
  ) u_if_id (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(if_id_clr),
    .en_i (~StallD),
    .d_i  (if_id_d),
    .q_o  (if_id_q)
  );

  assign imem_addr = pc_q;
  assign PCF       = pc_q;
  assign InstrD    = if_id_q.instr;
  assign PCPlus4D  = if_id_q.pc_plus4;
  assign ValidD    = if_id_q.valid;
  assign op        = if_id_q.instr[OP_MSB:OP_LSB];
  assign funct     = if_id_q.instr[FUNCT_MSB:FUNCT_LSB];

  // Holding decode while fetch advances would silently drop an instruction.
  a_stall_order : assert property (@(posedge clk) disable iff (!rst_n)
    StallD |-> StallF);

  // Misaligned branch targets are loaded as given, but flagged here.
  a_branch_align : assert property (@(posedge clk) disable iff (!rst_n)
    PCSrcM |-> (PCBranchM[1:0] == 2'b00));

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF, StallD, FlushD, PCSrcM, jump;
  logic [31:0] PCBranchM;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] PCF, InstrD, PCPlus4D;
  logic        ValidD;
  logic [5:0]  op, funct;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   j_seen = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcM(PCSrcM), .PCBranchM(PCBranchM), .jump(jump),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .op(op), .funct(funct)
  );

  // Instruction memory: a J (target index 0x40) at 0x10, and an
  // address-tagged lw everywhere else.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h0800_0040;
    return {6'h23, a[27:2]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  // Controller stand-in: decode J from the opcode in D.
  assign jump = (op == 6'b000010);

  function automatic exp_t fetched(input logic [31:0] pcf, input logic [31:0] a);
    return '{pcf: pcf, instr: mem_word(a), pc4: a + 32'd4, valid: 1'b1};
  endfunction

  function automatic exp_t bubble(input logic [31:0] pcf);
    return '{pcf: pcf, instr: 32'h0, pc4: 32'h0, valid: 1'b0};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input exp_t e);
    check_val({tag, ".pcf"},   PCF, e.pcf);
    check_val({tag, ".instr"}, InstrD, e.instr);
    check_val({tag, ".pc4"},   PCPlus4D, e.pc4);
    check_val({tag, ".valid"}, {31'b0, ValidD}, {31'b0, e.valid});
    check_val({tag, ".op"},    {26'b0, op}, {26'b0, e.instr[31:26]});
    check_val({tag, ".funct"}, {26'b0, funct}, {26'b0, e.instr[5:0]});
    $display("[%0t] %-12s PCF=%08h InstrD=%08h PCPlus4D=%08h ValidD=%0b", $time, tag,
             PCF, InstrD, PCPlus4D, ValidD);
  endtask

  // One clock: drive controls, push the expected post-edge state, then pop
  // and compare just after the edge.
  task automatic cyc(input string tag, input logic sf, input logic sd, input logic fd,
                     input logic br, input logic [31:0] tgt, input exp_t e);
    exp_t got;
    StallF = sf; StallD = sd; FlushD = fd; PCSrcM = br; PCBranchM = tgt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (op == 6'b000010) j_seen++;
    got = sb_q.pop_front();
    check_state(tag, got);
  endtask

  initial begin
    rst_n = 1'b0;
    StallF = 0; StallD = 0; FlushD = 0; PCSrcM = 0; PCBranchM = '0;
    #2;
    check_state("reset", bubble(32'h0));
    #10 rst_n = 1'b1;   // t=12, between edges

    // Sequential fetch, D trails PCF by one cycle.
    for (int k = 1; k <= 5; k++)
      cyc("seq", 0, 0, 0, 0, 0, fetched(32'(4 * k), 32'(4 * (k - 1))));
    // J in D: one bubble, then the target stream.
    cyc("jump_bub", 0, 0, 0, 0, 0, bubble(32'h100));
    cyc("jump_tgt", 0, 0, 0, 0, 0, fetched(32'h104, 32'h100));
    check_val("j_once", j_seen, 1);

    // Branch overrides both stalls.
    cyc("br_stall", 1, 1, 0, 1, 32'h200, bubble(32'h200));
    cyc("br_after", 0, 0, 0, 0, 0, fetched(32'h204, 32'h200));

    // Stall at 0x20 for three cycles.
    cyc("br_1c", 0, 0, 0, 1, 32'h1C, bubble(32'h1C));
    cyc("at_20", 0, 0, 0, 0, 0, fetched(32'h20, 32'h1C));
    for (int k = 0; k < 3; k++)
      cyc("stall", 1, 1, 0, 0, 0, fetched(32'h20, 32'h1C));
    cyc("resume", 0, 0, 0, 0, 0, fetched(32'h24, 32'h20));
    cyc("resume2", 0, 0, 0, 0, 0, fetched(32'h28, 32'h24));
    // Fetch stall only: D advances, same PC refetched.
    cyc("stallf", 1, 0, 0, 0, 0, fetched(32'h28, 32'h28));
    cyc("refetch", 0, 0, 0, 0, 0, fetched(32'h2C, 32'h28));
    cyc("flushd", 0, 0, 1, 0, 0, bubble(32'h30));

    // PC wrap-around.
    cyc("br_top", 0, 0, 0, 1, 32'hFFFF_FFFC, bubble(32'hFFFF_FFFC));
    cyc("wrap", 0, 0, 0, 0, 0, fetched(32'h0, 32'hFFFF_FFFC));
    cyc("wrap2", 0, 0, 0, 0, 0, fetched(32'h4, 32'h0));

    // Asynchronous reset mid-cycle while fetching 0x40.
    cyc("br_3c", 0, 0, 0, 1, 32'h3C, bubble(32'h3C));
    cyc("at_40", 0, 0, 0, 0, 0, fetched(32'h40, 32'h3C));
    #2 rst_n = 1'b0;
    #1 check_state("async_rst", bubble(32'h0));
    #2 rst_n = 1'b1;
    cyc("restart", 0, 0, 0, 0, 0, fetched(32'h4, 32'h0));
    cyc("restart2", 0, 0, 0, 0, 0, fetched(32'h8, 32'h4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
